// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state encoding and default datapath width
// for the arbitrated ALU.
package alu_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU shared by both requesters; flags any opcode
// outside the legal set and forces its result to zero.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] z,
  output logic             err
);

  always_comb begin
    z   = '0;
    err = 1'b0;
    case (op)
      OP_AND: z = a & b;
      OP_OR:  z = a | b;
      OP_ADD: z = a + b;
      OP_SUB: z = a - b;
      // Signed compare: the sign bits decide when a and b differ in sign.
      OP_SLT: z[0] = ($signed(a) < $signed(b));
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end to a single shared ALU, with an
// IDLE -> EXEC -> RESP sequence and a held response toward one consumer.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_z,
  output logic             rsp_zero,
  output logic             rsp_err
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high. reqN_ready is a combinational grant raised only in IDLE;
  // rsp_valid stays high with stable payload until rsp_ready is sampled high.

  state_t           state;
  state_t           state_nxt;
  logic             last;
  logic             grant_id;
  logic             accept;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       op_q;
  logic             id_q;
  logic [WIDTH-1:0] core_z;
  logic             core_err;

  // On a tie the requester not served last wins.
  assign grant_id = (req0_valid & req1_valid) ? ~last : req1_valid;
  assign accept   = req0_ready | req1_ready;

  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      ST_IDLE: begin
        if ((req0_valid | req1_valid) && rst_n) begin
          req0_ready = ~grant_id;
          req1_ready = grant_id;
          state_nxt  = ST_EXEC;
        end
      end
      ST_EXEC: state_nxt = ST_RESP;
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last     <= 1'b1;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      id_q     <= 1'b0;
      rsp_z    <= '0;
      rsp_zero <= 1'b0;
      rsp_err  <= 1'b0;
      rsp_id   <= 1'b0;
    end else begin
      if (accept) begin
        a_q  <= grant_id ? req1_a  : req0_a;
        b_q  <= grant_id ? req1_b  : req0_b;
        op_q <= grant_id ? req1_op : req0_op;
        id_q <= grant_id;
      end
      if (state == ST_EXEC) begin
        rsp_z    <= core_z;
        rsp_zero <= (core_z == '0);
        rsp_err  <= core_err;
        rsp_id   <= id_q;
      end
      // Fairness pointer moves only once the consumer has taken the result.
      if (state == ST_RESP && rsp_ready) last <= rsp_id;
    end
  end

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a   (a_q),
    .b   (b_q),
    .op  (op_q),
    .z   (core_z),
    .err (core_err)
  );

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus a randomized run checked
// against a plain-arithmetic model of the ALU and the round-robin rule.
module tb_alu_arbiter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]   req0_op, req1_op;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
  logic [W-1:0] rsp_z;

  int n_checks = 0;
  int n_pass = 0;
  int last_served = 1;
  logic [W-1:0] exp_q[$];
  int exp_id_q[$];
  logic exp_err_q[$];

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_z(rsp_z),
    .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] model_z(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    longint sa, sb;
    sa = a[W-1] ? longint'(a) - (longint'(1) << W) : longint'(a);
    sb = b[W-1] ? longint'(b) - (longint'(1) << W) : longint'(b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return W'(longint'(a) + longint'(b));
      3'd6: return W'(longint'(a) - longint'(b));
      3'd7: return (sa < sb) ? W'(1) : W'(0);
      default: return '0;
    endcase
  endfunction

  function automatic logic model_err(input logic [2:0] op);
    return !(op inside {3'd0, 3'd1, 3'd2, 3'd6, 3'd7});
  endfunction

  function automatic int model_winner(input logic v0, input logic v1);
    if (v0 && v1) return 1 - last_served;
    return v0 ? 0 : 1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic drive0(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
  endtask

  task automatic drive1(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; set_idle(); rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_served = 1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    req0_valid = 1'b1; req0_a = 0; req0_b = 0; req0_op = 0;
    req1_valid = 1'b0; req1_a = 0; req1_b = 0; req1_op = 0;
    rsp_ready = 1'b0;
    #2;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); else n_pass++;
    n_checks++; if (rsp_z !== '0) $display("FAIL reset_rsp_z: got %h want 0", rsp_z); else n_pass++;
    n_checks++; if ({rsp_zero, rsp_err, rsp_id} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {rsp_zero, rsp_err, rsp_id}); else n_pass++;
    n_checks++; if (req0_ready !== 1'b0) $display("FAIL reset_no_grant: got %b want 0", req0_ready); else n_pass++;
    @(negedge clk);
    set_idle(); rst_n = 1'b1;
    #1;
    n_checks++; if ({req0_ready, req1_ready, rsp_valid} !== 3'b000) $display("FAIL post_reset_idle: got %b want 000", {req0_ready, req1_ready, rsp_valid}); else n_pass++;
  endtask

  task automatic test_single();
    @(negedge clk);
    drive0(32'd5, 32'd7, 3'b010);
    #1;
    n_checks++; if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL single_ready: got %b want 10", {req0_ready, req1_ready}); else n_pass++;
    @(negedge clk);
    n_checks++; if ({rsp_valid, req0_ready} !== 2'b00) $display("FAIL single_exec: got %b want 00", {rsp_valid, req0_ready}); else n_pass++;
    set_idle();
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b1) $display("FAIL single_latency: got %b want 1", rsp_valid); else n_pass++;
    n_checks++; if (rsp_z !== 32'd12) $display("FAIL single_z: got %h want %h", rsp_z, 32'd12); else n_pass++;
    n_checks++; if ({rsp_id, rsp_zero, rsp_err} !== 3'b000) $display("FAIL single_flags: got %b want 000", {rsp_id, rsp_zero, rsp_err}); else n_pass++;
    rsp_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL single_release: got %b want 0", rsp_valid); else n_pass++;
    rsp_ready = 1'b0;
    last_served = 0;
  endtask

  task automatic test_tie();
    logic [W-1:0] a0, b0, a1, b1, exp;
    logic [2:0] op0, op1;
    int g, c;
    do_reset();
    a0 = $urandom; b0 = $urandom; op0 = 3'd2;
    a1 = $urandom; b1 = $urandom; op1 = 3'd6;
    rsp_ready = 1'b1;
    @(negedge clk);
    drive0(a0, b0, op0); drive1(a1, b1, op1);
    #1;
    for (int k = 0; k < 4; k++) begin
      g = -1;
      for (c = 0; c < 8 && g < 0; c++) begin
        if (req0_ready && req1_ready) begin
          n_checks++; $display("FAIL tie_both_ready: got 11 want one-hot");
        end
        if (req0_ready) g = 0;
        else if (req1_ready) g = 1;
        else @(negedge clk);
      end
      n_checks++; if (g != model_winner(1'b1, 1'b1) || g != (k % 2)) $display("FAIL tie_grant%0d: got %0d want %0d", k, g, k % 2); else n_pass++;
      if (g < 0) break;
      exp = (g == 0) ? model_z(a0, b0, op0) : model_z(a1, b1, op1);
      for (c = 0; c < 8 && !rsp_valid; c++) @(negedge clk);
      n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'(g)) $display("FAIL tie_rsp_id%0d: got valid %b id %b want 1 %0d", k, rsp_valid, rsp_id, g); else n_pass++;
      n_checks++; if (rsp_z !== exp) $display("FAIL tie_rsp_z%0d: got %h want %h", k, rsp_z, exp); else n_pass++;
      last_served = g;
      @(negedge clk);
    end
    set_idle();
    rsp_ready = 1'b0;
  endtask

  task automatic test_slt();
    logic [W-1:0] ta[4], tb[4], tz[4];
    logic [2:0] top[4];
    logic tzero[4];
    ta[0] = 32'hFFFF_FFFF; tb[0] = 32'd1;          top[0] = 3'b111; tz[0] = 32'd1; tzero[0] = 1'b0;
    ta[1] = 32'd1;          tb[1] = 32'hFFFF_FFFF; top[1] = 3'b111; tz[1] = 32'd0; tzero[1] = 1'b1;
    ta[2] = 32'd3;          tb[2] = 32'd3;          top[2] = 3'b110; tz[2] = 32'd0; tzero[2] = 1'b1;
    ta[3] = 32'hFFFF_FFFF; tb[3] = 32'd1;          top[3] = 3'b010; tz[3] = 32'd0; tzero[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive1(ta[i], tb[i], top[i]);
      #1;
      n_checks++; if ({req0_ready, req1_ready} !== 2'b01) $display("FAIL slt_ready%0d: got %b want 01", i, {req0_ready, req1_ready}); else n_pass++;
      @(negedge clk);
      set_idle();
      @(negedge clk);
      n_checks++; if (rsp_valid !== 1'b1 || rsp_z !== tz[i] || rsp_zero !== tzero[i] || rsp_err !== 1'b0)
        $display("FAIL slt_result%0d: got v%b z=%h zero=%b err=%b want v1 z=%h zero=%b err=0", i, rsp_valid, rsp_z, rsp_zero, rsp_err, tz[i], tzero[i]);
      else n_pass++;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      last_served = 1;
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a, b, exp;
    a = $urandom; b = $urandom;
    exp = model_z(a, b, 3'b001);
    @(negedge clk);
    drive0(a, b, 3'b001);
    @(negedge clk);
    set_idle();
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b1) $display("FAIL bp_valid: got %b want 1", rsp_valid); else n_pass++;
    drive0($urandom, $urandom, 3'b010); drive1($urandom, $urandom, 3'b010);
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++; if (rsp_valid !== 1'b1 || rsp_z !== exp || rsp_id !== 1'b0 || {req0_ready, req1_ready} !== 2'b00)
        $display("FAIL bp_hold%0d: got v%b z=%h id=%b rdy=%b want v1 z=%h id=0 rdy=00", i, rsp_valid, rsp_z, rsp_id, {req0_ready, req1_ready}, exp);
      else n_pass++;
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL bp_release: got %b want 0", rsp_valid); else n_pass++;
    set_idle(); rsp_ready = 1'b0;
    last_served = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (rsp_valid !== 1'b0) $display("FAIL bp_withdrawn%0d: got %b want 0", i, rsp_valid); else n_pass++;
    end
  endtask

  task automatic test_illegal();
    logic [2:0] ops[3];
    ops[0] = 3'b011; ops[1] = 3'b100; ops[2] = 3'b101;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive0($urandom | 32'h1, $urandom | 32'h1, ops[i]);
      @(negedge clk);
      set_idle();
      @(negedge clk);
      n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_z !== '0 || rsp_zero !== 1'b1)
        $display("FAIL illegal_op%0d: got v%b err=%b z=%h zero=%b want v1 err=1 z=0 zero=1", ops[i], rsp_valid, rsp_err, rsp_z, rsp_zero);
      else n_pass++;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      last_served = 0;
    end
  endtask

  task automatic test_reset_exec();
    @(negedge clk);
    drive1(32'd9, 32'd4, 3'b010);
    @(negedge clk);
    set_idle();
    rst_n = 1'b0;
    #1;
    n_checks++; if ({rsp_valid, rsp_zero, rsp_err, rsp_id} !== 4'b0000 || rsp_z !== '0)
      $display("FAIL rst_exec_clear: got v%b zero=%b err=%b id=%b z=%h want all 0", rsp_valid, rsp_zero, rsp_err, rsp_id, rsp_z);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    last_served = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++; if (rsp_valid !== 1'b0) $display("FAIL rst_exec_abandon%0d: got %b want 0", i, rsp_valid); else n_pass++;
    end
  endtask

  task automatic test_random();
    logic v0, v1;
    logic [W-1:0] a0, b0, a1, b1, exp;
    logic [2:0] op0, op1;
    logic exp_err;
    int w, exp_id, c, stall;
    for (int it = 0; it < 30; it++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
      a0 = $urandom; b0 = ($urandom_range(0, 3) == 0) ? a0 : $urandom; op0 = 3'($urandom_range(0, 7));
      a1 = $urandom; b1 = $urandom; op1 = 3'($urandom_range(0, 7));
      @(negedge clk);
      if (v0) drive0(a0, b0, op0);
      if (v1) drive1(a1, b1, op1);
      #1;
      w = model_winner(v0, v1);
      n_checks++; if (req0_ready !== (w == 0) || req1_ready !== (w == 1)) $display("FAIL rnd_grant%0d: got %b%b want winner %0d", it, req0_ready, req1_ready, w); else n_pass++;
      exp_q.push_back((w == 0) ? model_z(a0, b0, op0) : model_z(a1, b1, op1));
      exp_err_q.push_back((w == 0) ? model_err(op0) : model_err(op1));
      exp_id_q.push_back(w);
      @(negedge clk);
      set_idle();
      for (c = 0; c < 4 && !rsp_valid; c++) @(negedge clk);
      exp = exp_q.pop_front(); exp_err = exp_err_q.pop_front(); exp_id = exp_id_q.pop_front();
      stall = $urandom_range(0, 2);
      for (int s = 0; s <= stall; s++) begin
        n_checks++; if (rsp_valid !== 1'b1 || rsp_z !== exp || rsp_id !== 1'(exp_id) || rsp_err !== exp_err || rsp_zero !== (exp == '0))
          $display("FAIL rnd_rsp%0d: got v%b z=%h id=%b err=%b zero=%b want v1 z=%h id=%0d err=%b", it, rsp_valid, rsp_z, rsp_id, rsp_err, rsp_zero, exp, exp_id, exp_err);
        else n_pass++;
        if (s < stall) @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      last_served = w;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_slt();
    test_backpressure();
    test_illegal();
    test_reset_exec();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
